polyphase_interp_fir: RTL and testbench

POLYPHASE_INTERP_FIR -- requirements
Module: polyphase_interp_fir

---
 rtl/polyphase_interp_fir.sv | 120 ++++++++++++
 tb/tb_polyphase_interp_fir.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolating FIR: each accepted sample yields N_PHASE outputs,
// one phase per cycle, using runtime-loadable coefficients.
module polyphase_interp_fir #(
    parameter int NB_INPUT   = 8,
    parameter int NBF_INPUT  = 7,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 7,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 7,
    parameter int N_PHASE    = 4,
    parameter int N_TAPS     = 6
) (
    input  logic                                clock,
    input  logic                                i_reset,
    input  logic                                i_valid,
    input  logic signed [NB_INPUT-1:0]          i_data,
    output logic                                o_ready,
    input  logic                                i_coeff_we,
    input  logic [$clog2(N_PHASE*N_TAPS)-1:0]   i_coeff_addr,
    input  logic signed [NB_COEFF-1:0]          i_coeff_data,
    output logic                                o_valid,
    output logic signed [NB_OUTPUT-1:0]         o_data,
    output logic [$clog2(N_PHASE)-1:0]          o_phase,
    output logic                                o_sat
);

    localparam int N_COEFF  = N_PHASE * N_TAPS;
    localparam int NB_ADDR  = $clog2(N_COEFF);
    localparam int NB_PHASE = $clog2(N_PHASE);
    localparam int NB_ACC   = NB_INPUT + NB_COEFF + $clog2(N_TAPS);
    localparam int SHIFT    = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;
    localparam int NB_TOP   = NB_ACC - SHIFT - NB_OUTPUT + 1;

    localparam logic [NB_PHASE-1:0] LAST_P   = NB_PHASE'(N_PHASE - 1);
    localparam logic [NB_ADDR:0]    ADDR_LIM = (NB_ADDR + 1)'(N_COEFF);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state;
    logic [NB_PHASE-1:0]         p;
    logic signed [NB_INPUT-1:0]  x     [N_TAPS];
    logic signed [NB_COEFF-1:0]  coeff [N_COEFF];
    logic signed [NB_ACC-1:0]    acc;
    logic [NB_TOP-1:0]           top;
    logic                        ovf;
    logic signed [NB_OUTPUT-1:0] sat_data;
    logic                        accept;
    logic                        last;
    logic                        addr_ok;

    assign last    = (p == LAST_P);
    assign o_ready = i_reset && ((state == IDLE) || last);
    assign accept  = i_valid && o_ready;
    assign addr_ok = ({1'b0, i_coeff_addr} < ADDR_LIM);

    // Phase p uses every N_PHASE-th coefficient starting at p.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc = acc
                + NB_ACC'(coeff[NB_ADDR'(p) + NB_ADDR'(k * N_PHASE)])
                * NB_ACC'(x[k]);
        end
    end

    // Discarded integer bits plus the output sign must all agree.
    always_comb begin
        top      = acc[NB_ACC-1 -: NB_TOP];
        ovf      = !((&top) || !(|top));
        sat_data = acc[SHIFT +: NB_OUTPUT];
        if (ovf) begin
            sat_data = acc[NB_ACC-1]
                     ? {1'b1, {(NB_OUTPUT-1){1'b0}}}
                     : {1'b0, {(NB_OUTPUT-1){1'b1}}};
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state   <= IDLE;
            p       <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_phase <= '0;
            o_sat   <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
            for (int i = 0; i < N_COEFF; i++) coeff[i] <= '0;
        end else begin
            o_valid <= (state == RUN);
            o_sat   <= (state == RUN) && ovf;
            if (state == RUN) begin
                o_data  <= sat_data;
                o_phase <= p;
            end
            if (i_coeff_we && addr_ok) coeff[i_coeff_addr] <= i_coeff_data;
            if (accept) begin
                for (int k = N_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                x[0] <= i_data;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        p     <= '0;
                    end
                end
                RUN: begin
                    if (!last) begin
                        p <= p + NB_PHASE'(1);
                    end else begin
                        p <= '0;
                        if (!accept) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Randomized and directed bench for polyphase_interp_fir against a
// job-queue reference model of the interpolator.
module tb_polyphase_interp_fir;

    localparam int NP    = 4;
    localparam int NT    = 6;
    localparam int NC    = NP * NT;
    localparam int NBA   = $clog2(NC);
    localparam int SHIFT = 7;
    localparam int OMAX  = 127;
    localparam int OMIN  = -128;

    logic           clock = 1'b0;
    logic           i_reset;
    logic           i_valid;
    logic [7:0]     i_data;
    logic           o_ready;
    logic           i_coeff_we;
    logic [NBA-1:0] i_coeff_addr;
    logic [7:0]     i_coeff_data;
    logic           o_valid;
    logic [7:0]     o_data;
    logic [1:0]     o_phase;
    logic           o_sat;

    always #5 clock = ~clock;

    polyphase_interp_fir dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_coeff_we   (i_coeff_we),
        .i_coeff_addr (i_coeff_addr),
        .i_coeff_data (i_coeff_data),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_phase      (o_phase),
        .o_sat        (o_sat)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Model: each accepted sample queues N_PHASE phase jobs, one served per cycle.
    int q[$];
    int hist[NT];
    int cf[NC];
    int e_valid = 0;
    int e_sat   = 0;
    int e_data  = 0;
    int e_phase = 0;

    bit last_acc;
    bit cap_en = 0;
    int cap_d[$];
    int cap_s[$];
    int cap_c[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    endtask

    task automatic cycle(input bit v, input int d, input bit we,
                         input int a, input int cd, input bit rn);
        bit     rdy;
        int     job;
        longint acc;
        longint t;
        i_valid      = v;
        i_data       = d[7:0];
        i_coeff_we   = we;
        i_coeff_addr = a[NBA-1:0];
        i_coeff_data = cd[7:0];
        i_reset      = rn;
        rdy = rn && (q.size() <= 1);
        #1;
        chk("o_ready", int'(o_ready), int'(rdy));
        last_acc = v && rdy;
        if (!rn) begin
            q.delete();
            for (int k = 0; k < NT; k++) hist[k] = 0;
            for (int i = 0; i < NC; i++) cf[i] = 0;
            e_valid = 0; e_sat = 0; e_data = 0; e_phase = 0;
        end else begin
            if (q.size() > 0) begin
                job = q.pop_front();
                acc = 0;
                for (int k = 0; k < NT; k++) acc += longint'(cf[job + k*NP]) * hist[k];
                t = acc >>> SHIFT;
                e_sat = 0;
                if (t > OMAX) begin t = OMAX; e_sat = 1; end
                if (t < OMIN) begin t = OMIN; e_sat = 1; end
                e_data  = int'(t);
                e_phase = job;
                e_valid = 1;
            end else begin
                e_valid = 0;
                e_sat   = 0;
            end
            if (we && a < NC) cf[a] = int'($signed(cd[7:0]));
            if (last_acc) begin
                for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'($signed(d[7:0]));
                for (int p = 0; p < NP; p++) q.push_back(p);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        chk("o_valid", int'(o_valid), e_valid);
        chk("o_sat",   int'(o_sat),   e_sat);
        chk("o_data",  int'($signed(o_data)), e_data);
        chk("o_phase", int'(o_phase), e_phase);
        if (cap_en && o_valid) begin
            cap_d.push_back(int'($signed(o_data)));
            cap_s.push_back(int'(o_sat));
            cap_c.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic wcoef(input int a, input int v);
        cycle(0, 0, 1, a, v, 1);
    endtask

    task automatic send(input int d, output int n);
        n = 0;
        do begin
            cycle(1, d, 0, 0, 0, 1);
            n++;
        end while (!last_acc && n < 64);
        chk("send_accept", int'(last_acc), 1);
    endtask

    task automatic cap_start();
        cap_d.delete();
        cap_s.delete();
        cap_c.delete();
        cap_en = 1;
    endtask

    initial begin
        int n;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 'h33, 1, 3, 'h44, 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data",  int'(o_data), 0);

        // Impulse through coefficients 1..24
        for (int i = 0; i < NC; i++) wcoef(i, i + 1);
        cap_start();
        send('h7F, n);
        for (int i = 0; i < 5; i++) send(0, n);
        idle(6);
        cap_en = 0;
        chk("imp_count", cap_d.size(), NC);
        for (int i = 0; i < NC; i++)
            chk("imp_val", (i < cap_d.size()) ? cap_d[i] : -999, i);

        // Back-to-back samples, no output bubble
        cap_start();
        send('h10, n);
        send('h20, n);
        idle(6);
        cap_en = 0;
        chk("b2b_count", cap_c.size(), 8);
        chk("b2b_span", (cap_c.size() >= 8) ? cap_c[7] - cap_c[0] : -1, 7);

        // Saturation both ways
        for (int i = 0; i < NC; i++) wcoef(i, 'h7F);
        cap_start();
        for (int i = 0; i < NT; i++) send('h7F, n);
        idle(6);
        chk("sat_pos_data", (cap_d.size() > 0) ? cap_d[$] : 0, 127);
        chk("sat_pos_flag", (cap_s.size() > 0) ? cap_s[$] : 0, 1);
        cap_start();
        for (int i = 0; i < NT; i++) send('h80, n);
        idle(6);
        cap_en = 0;
        chk("sat_neg_data", (cap_d.size() > 0) ? cap_d[$] : 0, -128);
        chk("sat_neg_flag", (cap_s.size() > 0) ? cap_s[$] : 0, 1);

        // Stall: request at p=1 waits until p=3
        send('h15, n);
        idle(1);
        send('h25, n);
        chk("stall_cycles", n, 3);
        idle(6);

        // Reset pulse at p=2 aborts the burst
        send('h55, n);
        idle(2);
        cycle(0, 0, 0, 0, 0, 0);
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_data",  int'(o_data), 0);
        chk("midrst_phase", int'(o_phase), 0);

        // Coefficient writes during RUN, from zeroed history
        wcoef(0, 'h40);
        cap_start();
        send('h40, n);
        cycle(0, 0, 1, 1, 'h20, 1);
        cycle(0, 0, 1, 2, 'h30, 1);
        cycle(0, 0, 1, 2, 'h7F, 1);
        idle(4);
        cap_en = 0;
        chk("cw_p0", (cap_d.size() > 0) ? cap_d[0] : -999, 32);
        chk("cw_p1", (cap_d.size() > 1) ? cap_d[1] : -999, 16);
        chk("cw_p2", (cap_d.size() > 2) ? cap_d[2] : -999, 24);
        chk("cw_p3", (cap_d.size() > 3) ? cap_d[3] : -999, 0);

        // Out-of-range writes must not alias
        wcoef(NC, 'h7F);
        wcoef(31, 'h7F);
        send('h7F, n);
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
                  $urandom_range(0, 255), ($urandom_range(0, 299) != 0));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
